// File: rtl/m31_mul_pipe.sv
// Streaming (a*b) mod (2^31-1): 62-bit product, two folds, final conditional subtract; canonical output.
// Latency 3 cycles, one result per cycle; a stalled output backs up through ready_k = !valid_k || ready_{k+1}.
module m31_mul_pipe #(
  parameter int TAG_WIDTH    = 4,
  parameter bit CANONICAL_IN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [30:0]          in_a,
  input  logic [30:0]          in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [30:0]          out_data,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam logic [31:0] P32 = 32'h7FFF_FFFF;
  localparam logic [30:0] P31 = 31'h7FFF_FFFF;

  logic                 s1_vld, s2_vld, s3_vld;
  logic                 s1_rdy, s2_rdy, s3_rdy;
  logic [61:0]          s1_dat;
  logic [31:0]          s2_dat;
  logic [30:0]          s3_dat;
  logic [TAG_WIDTH-1:0] s1_tag, s2_tag, s3_tag;

  logic [61:0] prod_c;
  logic [31:0] fold1_c;
  logic [31:0] fold2_c;
  logic [30:0] red_c;

  assign s3_rdy   = !s3_vld || out_ready;
  assign s2_rdy   = !s2_vld || s3_rdy;
  assign s1_rdy   = !s1_vld || s2_rdy;
  assign in_ready = s1_rdy;

  // 2^31 == 1 (mod p), so the high half folds onto the low half by addition.
  assign prod_c  = 62'(in_a) * 62'(in_b);
  assign fold1_c = {1'b0, s1_dat[30:0]} + {1'b0, s1_dat[61:31]};
  assign fold2_c = {1'b0, s2_dat[30:0]} + {31'b0, s2_dat[31]};
  assign red_c   = (fold2_c >= P32) ? 31'(fold2_c - P32) : fold2_c[30:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
      s1_tag <= '0;
    end else if (s1_rdy) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_dat <= prod_c;
        s1_tag <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
      s2_tag <= '0;
    end else if (s2_rdy) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_dat <= fold1_c;
        s2_tag <= s1_tag;
      end
    end
  end

  // Output register is held while the consumer stalls, keeping data/tag stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld <= 1'b0;
      s3_dat <= '0;
      s3_tag <= '0;
    end else if (s3_rdy) begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_dat <= red_c;
        s3_tag <= s2_tag;
      end
    end
  end

  assign out_valid = s3_vld;
  assign out_data  = s3_dat;
  assign out_tag   = s3_tag;

  // Caller contract only; the datapath handles the value p either way.
  if (CANONICAL_IN) begin : g_canon_chk
    always_ff @(posedge clk) begin
      if (rst_n && in_valid && in_ready)
        assert (in_a != P31 && in_b != P31);
    end
  end

endmodule

// File: tb/tb_m31_mul_pipe.sv
// Scoreboard bench for m31_mul_pipe: directed folds, latency, streaming, random stalls, mid-stall reset.
module tb_m31_mul_pipe;

  localparam int TW = 4;
  localparam logic [30:0] P = 31'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [30:0]   in_a = '0;
  logic [30:0]   in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [30:0]   out_data;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  m31_mul_pipe #(.TAG_WIDTH(TW), .CANONICAL_IN(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  typedef struct packed {
    logic [30:0]   dat;
    logic [TW-1:0] tag;
    logic [31:0]   cyc;
  } exp_t;

  exp_t        sb[$];
  logic [30:0] drv_exp = '0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_acc = 0;
  int          n_pop = 0;
  logic [31:0] cyc = '0;
  bit          lat_on = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [30:0] gold(input logic [30:0] a, input logic [30:0] b);
    logic [63:0] pr;
    pr = 64'(a) * 64'(b);
    return 31'(pr % 64'h7FFF_FFFF);
  endfunction

  function automatic logic [30:0] modpow(input logic [30:0] base, input logic [30:0] e);
    logic [63:0] r, x;
    r = 64'd1;
    x = 64'(base) % 64'h7FFF_FFFF;
    for (int i = 0; i < 31; i++) begin
      if (e[i]) r = (r * x) % 64'h7FFF_FFFF;
      x = (x * x) % 64'h7FFF_FFFF;
    end
    return 31'(r);
  endfunction

  // Runs at the falling edge: checks outputs against the scoreboard and records acceptances.
  task automatic monitor();
    exp_t e;
    cyc++;
    check("in_ready", in_ready, (sb.size() < 3) || out_ready);
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("out_valid_unexpected", out_valid, 0);
      end else begin
        check("out_data", out_data, sb[0].dat);
        check("out_tag", out_tag, sb[0].tag);
        if (out_ready) begin
          if (lat_on) check("latency", cyc - sb[0].cyc, 3);
          void'(sb.pop_front());
          n_pop++;
        end
      end
    end
    if (in_valid && in_ready) begin
      e.dat = drv_exp;
      e.tag = in_tag;
      e.cyc = cyc;
      sb.push_back(e);
      n_acc++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [30:0] a, input logic [30:0] b, input logic [30:0] exp,
                      input logic [TW-1:0] tag);
    int acc0;
    int t;
    acc0 = n_acc;
    t = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = tag;
    drv_exp = exp;
    while (n_acc == acc0 && t < 50) begin
      tick();
      t++;
    end
    if (n_acc == acc0) check("send_accept_timeout", n_acc - acc0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && t < limit) begin
      tick();
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  logic [30:0] dir_a [7] = '{31'd0, P - 31'd1, 31'h4000_0000, P, P, P - 31'd1, 31'd46341};
  logic [30:0] dir_b [7] = '{31'd12345, P - 31'd1, 31'd2, 31'd5, P, 31'd2, 31'd46341};
  logic [30:0] dir_e [7] = '{31'd0, 31'd1, 31'd1, 31'd0, 31'd0, 31'h7FFF_FFFD, 31'd4634};

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [30:0] a, b;
    int acc0, pop0, guard;

    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed values, each alone so latency is measured from an empty pipe.
    lat_on = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(dir_a[i], dir_b[i], dir_e[i], TW'(i));
      for (int k = 0; k < 4; k++) tick();
    end
    // f2 == p (operand p times anything nonzero) and products congruent to 1.
    for (int i = 0; i < 8; i++) begin
      a = 31'($urandom_range(1, 32'h7FFF_FFFE));
      if (i[0]) send(a, P, 31'd0, TW'(i));
      else      send(P, a, 31'd0, TW'(i));
      send(a, modpow(a, P - 31'd2), 31'd1, TW'(i + 1));
    end
    drain(20);
    lat_on = 1'b0;

    // Back-to-back stream: one acceptance and, after fill, one result per cycle.
    pop0 = n_pop;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = 31'($urandom);
      b = 31'($urandom);
      if ($urandom_range(0, 15) == 0) a = P;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_tag = TW'($urandom);
      drv_exp = gold(a, b);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("stream_count", n_pop - pop0, 1000);

    // Random valid and ready; stalled outputs are rechecked every cycle against the same entry.
    acc0 = n_acc;
    guard = 0;
    while (n_acc - acc0 < 5000 && guard < 40000) begin
      a = 31'($urandom);
      b = 31'($urandom);
      if ($urandom_range(0, 31) == 0) b = P;
      in_valid = 1'($urandom_range(0, 1));
      in_a = a;
      in_b = b;
      in_tag = TW'($urandom);
      drv_exp = gold(a, b);
      out_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    check("random_accepted", n_acc - acc0, 5000);
    drain(20);

    // Fill three under stall, then reset mid-stall: nothing may come out afterwards.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(31'(i + 7), 31'd3, 31'((i + 7) * 3), TW'(i));
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("postrst_quiet", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
